// File: rtl/spw_rx_data_in_port.sv
// SpaceWire RX data input port: buffers link-core words in a FIFO and exposes them to the CPU
// through a 4-register Avalon-MM window. Optional macro SPW_RX_DROP_ON_FULL_EN: drop-and-flag at full.
module spw_rx_data_in_port #(
  parameter int DATA_WIDTH = 9,
  parameter int FIFO_DEPTH = 16,
  parameter int PTR_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  read_n,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  irq
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;
  logic                  overflow;
  logic                  rx_enable;
  logic [1:0]            irq_mask;

  logic empty, full, bus_rd, bus_wr, pop, flush, push, drop;
  logic unused_bits;

  assign unused_bits = &{1'b0, writedata[31:19], writedata[17:2]};

  always_comb begin
    empty  = (count == '0);
    full   = (count == FULL_CNT);
    bus_rd = chipselect & ~read_n;
    bus_wr = chipselect & ~write_n;
    pop    = bus_rd & (address == 2'd0) & ~empty;
    flush  = bus_wr & (address == 2'd3) & writedata[1];
`ifdef SPW_RX_DROP_ON_FULL_EN
    in_ready = ~reset & rx_enable;
    push     = in_valid & in_ready & (~full | pop);
    drop     = in_valid & in_ready & full & ~pop & ~flush;
`else
    // a same-cycle pop frees the slot, so the link may refill it even at full
    in_ready = ~reset & rx_enable & (~full | pop);
    push     = in_valid & in_ready;
    drop     = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      rx_enable <= 1'b0;
      irq_mask  <= 2'b00;
      irq       <= 1'b0;
    end else begin
      if (bus_wr && address == 2'd2) irq_mask  <= writedata[1:0];
      if (bus_wr && address == 2'd3) rx_enable <= writedata[0];

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end

      // a fresh drop wins over a same-cycle clear so no loss goes unreported
      if (drop) overflow <= 1'b1;
      else if (bus_wr && address == 2'd1 && writedata[18]) overflow <= 1'b0;

      irq <= (irq_mask[0] & ~empty) | (irq_mask[1] & overflow);
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: if (!empty) begin
        readdata[DATA_WIDTH-1:0] = mem[rd_ptr];
        readdata[31]             = 1'b1;
      end
      2'd1: begin
        readdata[PTR_W:0] = count;
        readdata[16]      = empty;
        readdata[17]      = full;
        readdata[18]      = overflow;
      end
      2'd2:    readdata[1:0] = irq_mask;
      default: readdata[0]   = rx_enable;
    endcase
  end

endmodule

// File: tb/tb_spw_rx_data_in_port.sv
// Directed self-checking bench for spw_rx_data_in_port (default build; drop-on-full steps
// are compiled in when SPW_RX_DROP_ON_FULL_EN is defined).
module tb_spw_rx_data_in_port;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [8:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spw_rx_data_in_port #(.DATA_WIDTH(9), .FIFO_DEPTH(16), .PTR_W(4)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1; read_n = 1'b0; address = a;
    #1 d = readdata;
    tick();
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1 d = readdata;
  endtask

  task automatic push_word(input logic [8:0] w);
    in_data = w; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] dword(input logic [8:0] w);
    return {1'b1, 22'b0, w};
  endfunction

  initial begin
    logic [31:0] got;
    logic [8:0]  w;
    logic [8:0]  q[$];

    #1 chk("in_ready_in_reset", {31'b0, in_ready}, 32'h0);
    tick(); tick();
    reset = 1'b0;
    #1;
    peek(2'd1, got); chk("reset_status", got, 32'h0001_0000);
    peek(2'd3, got); chk("reset_ctrl", got, 32'h0);
    peek(2'd2, got); chk("reset_irqmsk", got, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    chk("reset_in_ready", {31'b0, in_ready}, 32'h0);

    // T1 basic push/pop
    wr(2'd3, 32'h1);
    chk("t1_in_ready", {31'b0, in_ready}, 32'h1);
    push_word(9'h1AB);
    push_word(9'h042);
    peek(2'd1, got); chk("t1_status", got, 32'h0000_0002);
    rd(2'd0, got); chk("t1_rd0", got, 32'h8000_01AB);
    rd(2'd0, got); chk("t1_rd1", got, 32'h8000_0042);
    rd(2'd0, got); chk("t1_rd_empty", got, 32'h0);
    peek(2'd1, got); chk("t1_status_empty", got, 32'h0001_0000);

    // T2 fill, then pop with a concurrent push at full
    for (int i = 0; i < 16; i++) push_word(9'(i + 16));
    peek(2'd1, got); chk("t2_status_full", got, 32'h0002_0010);
    chk("t2_in_ready_full", {31'b0, in_ready}, 32'h0);
    in_data = 9'h0FF; in_valid = 1'b1;
    rd(2'd0, got); chk("t2_pop_head", got, 32'h8000_0010);
    in_valid = 1'b0;
    peek(2'd1, got); chk("t2_status_still_full", got, 32'h0002_0010);
    for (int i = 1; i < 16; i++) begin
      rd(2'd0, got); chk("t2_drain", got, dword(9'(i + 16)));
    end
    rd(2'd0, got); chk("t2_drain_refill", got, 32'h8000_00FF);
    peek(2'd1, got); chk("t2_status_empty", got, 32'h0001_0000);

    // T3 20 words across pointer wrap, interleaved pops
    for (int i = 0; i < 20; i++) begin
      w = 9'(i * 37 + 5);
      push_word(w);
      q.push_back(w);
      if (i % 2 == 1) begin
        w = q.pop_front();
        rd(2'd0, got); chk("t3_pop", got, dword(w));
      end
    end
    while (q.size() > 0) begin
      w = q.pop_front();
      rd(2'd0, got); chk("t3_drain", got, dword(w));
    end
    peek(2'd1, got); chk("t3_status_empty", got, 32'h0001_0000);

    // T4 non-empty interrupt timing
    wr(2'd2, 32'h1);
    chk("t4_irq_idle", {31'b0, irq}, 32'h0);
    push_word(9'h155);
    chk("t4_irq_lag", {31'b0, irq}, 32'h0);
    tick();
    chk("t4_irq_set", {31'b0, irq}, 32'h1);
    rd(2'd0, got); chk("t4_pop", got, 32'h8000_0155);
    chk("t4_irq_hold", {31'b0, irq}, 32'h1);
    tick();
    chk("t4_irq_clear", {31'b0, irq}, 32'h0);
    wr(2'd2, 32'h0);

    // T5 flush discards a same-cycle push
    for (int i = 0; i < 5; i++) push_word(9'(i + 1));
    peek(2'd1, got); chk("t5_count5", got, 32'h0000_0005);
    in_data = 9'h0AA; in_valid = 1'b1;
    wr(2'd3, 32'h3);
    in_valid = 1'b0;
    peek(2'd1, got); chk("t5_status_flushed", got, 32'h0001_0000);
    peek(2'd3, got); chk("t5_ctrl_selfclear", got, 32'h1);
    peek(2'd0, got); chk("t5_data_empty", got, 32'h0);

    // rx_enable off retains contents
    push_word(9'h123);
    wr(2'd3, 32'h0);
    chk("dis_in_ready", {31'b0, in_ready}, 32'h0);
    push_word(9'h0EE);
    peek(2'd1, got); chk("dis_count", got, 32'h0000_0001);
    rd(2'd0, got); chk("dis_readable", got, 32'h8000_0123);

    // reset mid-operation
    wr(2'd3, 32'h1);
    wr(2'd2, 32'h3);
    push_word(9'h077);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    peek(2'd1, got); chk("mid_reset_status", got, 32'h0001_0000);
    peek(2'd3, got); chk("mid_reset_ctrl", got, 32'h0);
    peek(2'd2, got); chk("mid_reset_irqmsk", got, 32'h0);
    chk("mid_reset_irq", {31'b0, irq}, 32'h0);

`ifdef SPW_RX_DROP_ON_FULL_EN
    // T6 drop-on-full and overflow interrupt
    wr(2'd3, 32'h1);
    for (int i = 0; i < 16; i++) push_word(9'(i + 32));
    chk("t6_in_ready_full", {31'b0, in_ready}, 32'h1);
    push_word(9'h100);
    peek(2'd1, got); chk("t6_status_ovf", got, 32'h0006_0010);
    wr(2'd2, 32'h2);
    tick();
    chk("t6_irq_ovf", {31'b0, irq}, 32'h1);
    wr(2'd1, 32'h0004_0000);
    peek(2'd1, got); chk("t6_ovf_cleared", got, 32'h0002_0010);
    rd(2'd0, got); chk("t6_head_intact", got, 32'h8000_0020);
    tick();
    chk("t6_irq_cleared", {31'b0, irq}, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
